// File: rtl/reg_bank_wr_arbiter.sv
// Round-robin write-port arbiter for the register bank.
// Four requesters compete for the single write port; the winner's data goes onto
// the shared reg_d bus and its target register gets a one-cycle enable, unless
// that register is write-protected, in which case the write is dropped and err
// pulses alongside ack. Every output is driven straight from a flop.
module reg_bank_wr_arbiter #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [3:0]               req,
  input  logic [4*ADDR_W-1:0]      req_addr,
  input  logic [4*DATA_W-1:0]      req_data,
  input  logic [(2**ADDR_W)-1:0]   wp_mask,
  output logic [3:0]               ack,
  output logic                     err,
  output logic [(2**ADDR_W)-1:0]   reg_en,
  output logic [DATA_W-1:0]        reg_d,
  output logic                     busy
);

  localparam int unsigned NREG = 2 ** ADDR_W;
  localparam logic [NREG-1:0] EnLsb = {{(NREG - 1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {StIdle, StWrite} state_e;

  state_e              state_q, state_d;
  logic [1:0]          ptr_q, ptr_d;
  logic [3:0]          ack_q, ack_d;
  logic                err_q, err_d;
  logic [NREG-1:0]     reg_en_q, reg_en_d;
  logic [DATA_W-1:0]   reg_d_q, reg_d_d;

  logic [1:0]          cand;
  logic [1:0]          win;
  logic                found;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_data;

  // Round-robin scan starting at ptr_q; first requester found wins.
  always_comb begin
    cand  = '0;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    win_addr = req_addr[int'(win)*ADDR_W +: ADDR_W];
    win_data = req_data[int'(win)*DATA_W +: DATA_W];
  end

  // Next-state: grant in IDLE, single WRITE cycle clears the pulses.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    ack_d    = '0;
    err_d    = 1'b0;
    reg_en_d = '0;
    reg_d_d  = reg_d_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d = StWrite;
          ack_d   = 4'b0001 << win;
          reg_d_d = win_data;
          ptr_d   = win + 2'd1;
          if (wp_mask[win_addr]) begin
            err_d = 1'b1;
          end else begin
            reg_en_d = EnLsb << win_addr;
          end
        end
      end
      StWrite: begin
        // reg_d is held so the bank captures it at the edge ending this cycle.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs; synchronous reset aborts any in-flight write.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      ack_q    <= '0;
      err_q    <= 1'b0;
      reg_en_q <= '0;
      reg_d_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      reg_en_q <= reg_en_d;
      reg_d_q  <= reg_d_d;
    end
  end

  assign ack    = ack_q;
  assign err    = err_q;
  assign reg_en = reg_en_q;
  assign reg_d  = reg_d_q;
  assign busy   = (state_q == StWrite);

endmodule
